// File: rtl/snake_body.sv
// snake_body: snake movement and body-storage controller for the VGA snake game.
// Advances the head one grid cell per move_tick, shifts the body, grows the
// body when points rise, and freezes on lose, win or a wall hit.
// Build option: define SNAKE_WRAP_EN to wrap the head to the opposite edge
// instead of stopping at the field boundary.
module snake_body #(
    parameter int MAX_LEN = 23,
    parameter int STEP    = 20,
    parameter int X_MAX   = 620,
    parameter int Y_MAX   = 460,
    parameter int START_X = 320,
    parameter int START_Y = 240
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   move_tick,
    input  logic                   btn_up,
    input  logic                   btn_down,
    input  logic                   btn_left,
    input  logic                   btn_right,
    input  logic [5:0]             points,
    input  logic                   lose,
    input  logic                   win,
    output logic [11*MAX_LEN-1:0]  snakepos_x,
    output logic [11*MAX_LEN-1:0]  snakepos_y,
    output logic [5:0]             length,
    output logic                   moved,
    output logic                   wall_hit
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FROZEN} state_t;
    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

    localparam logic [10:0] STEP_W    = 11'(STEP);
    localparam logic [10:0] X_MAX_W   = 11'(X_MAX);
    localparam logic [10:0] Y_MAX_W   = 11'(Y_MAX);
    localparam logic [10:0] START_X_W = 11'(START_X);
    localparam logic [10:0] START_Y_W = 11'(START_Y);
    localparam logic [5:0]  MAX_LEN_W = 6'(MAX_LEN);

    state_t      state;
    dir_t        dir;
    logic [10:0] seg_x [MAX_LEN];
    logic [10:0] seg_y [MAX_LEN];
    logic [5:0]  prev_points;
    logic [2:0]  grow_pending;
    logic        wall_q;

    logic        btn_any;
    dir_t        req_dir;
    dir_t        eff_dir;
    logic        freeze;
    logic        out_of_range;
    logic        blocked;
    logic        do_move;
    logic [10:0] head_x_next;
    logic [10:0] head_y_next;
    logic [5:0]  pts_diff;
    logic [2:0]  grow_base;
    logic [6:0]  grow_sum;
    logic [2:0]  grow_next;

    function automatic dir_t opposite(input dir_t d);
        case (d)
            DIR_UP:   return DIR_DOWN;
            DIR_DOWN: return DIR_UP;
            DIR_LEFT: return DIR_RIGHT;
            default:  return DIR_LEFT;
        endcase
    endfunction

    // Resolve button priority and the direction that applies to a move this cycle.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        btn_any = btn_up | btn_down | btn_left | btn_right;
        req_dir = DIR_RIGHT;
        if (btn_up)        req_dir = DIR_UP;
        else if (btn_down) req_dir = DIR_DOWN;
        else if (btn_left) req_dir = DIR_LEFT;
        eff_dir = dir;
        if (state == ST_RUN && btn_any && req_dir != opposite(dir))
            eff_dir = req_dir;
    end

    // Candidate head position; out-of-range is tested before 11-bit wrap-around.
    always_comb begin
        head_x_next  = seg_x[0];
        head_y_next  = seg_y[0];
        out_of_range = 1'b0;
        case (eff_dir)
            DIR_UP: begin
                out_of_range = seg_y[0] < STEP_W;
                head_y_next  = out_of_range ? Y_MAX_W : seg_y[0] - STEP_W;
            end
            DIR_DOWN: begin
                out_of_range = (seg_y[0] + STEP_W) > Y_MAX_W;
                head_y_next  = out_of_range ? 11'd0 : seg_y[0] + STEP_W;
            end
            DIR_LEFT: begin
                out_of_range = seg_x[0] < STEP_W;
                head_x_next  = out_of_range ? X_MAX_W : seg_x[0] - STEP_W;
            end
            default: begin
                out_of_range = (seg_x[0] + STEP_W) > X_MAX_W;
                head_x_next  = out_of_range ? 11'd0 : seg_x[0] + STEP_W;
            end
        endcase
    end

`ifdef SNAKE_WRAP_EN
    assign blocked  = 1'b0;
    assign wall_hit = 1'b0;
`else
    assign blocked  = out_of_range;
    assign wall_hit = wall_q;
`endif

    assign freeze  = lose | win | wall_q;
    assign do_move = (state == ST_RUN) && !freeze && move_tick && !blocked;

    // Growth bookkeeping: consume one pending segment per move, then add new points.
    always_comb begin
        pts_diff  = (points > prev_points) ? points - prev_points : 6'd0;
        grow_base = grow_pending;
        if (do_move) begin
            if (length < MAX_LEN_W)
                grow_base = (grow_pending != 3'd0) ? grow_pending - 3'd1 : 3'd0;
            else
                grow_base = 3'd0;
        end
        grow_sum  = {4'd0, grow_base} + {1'b0, pts_diff};
        grow_next = (grow_sum > 7'd7) ? 3'd7 : grow_sum[2:0];
    end

    // State, direction, body storage and growth registers.
    always_ff @(posedge clk) begin
        // NOTE: the body arrays are plain registers, so resetting them is legal and
        // gives the renderer a defined snake straight out of reset.
        if (reset) begin
            state        <= ST_IDLE;
            dir          <= DIR_RIGHT;
            prev_points  <= 6'd2;
            grow_pending <= 3'd0;
            length       <= 6'd2;
            moved        <= 1'b0;
            wall_q       <= 1'b0;
            seg_x[0]     <= START_X_W;
            seg_y[0]     <= START_Y_W;
            for (int i = 1; i < MAX_LEN; i++) begin
                seg_x[i] <= START_X_W - STEP_W;
                seg_y[i] <= START_Y_W;
            end
        end else begin
            // NOTE: non-blocking assignments keep every register reading pre-edge values.
            moved        <= 1'b0;
            grow_pending <= grow_next;
            if (points > prev_points)
                prev_points <= points;
            case (state)
                ST_IDLE: begin
                    if (btn_any) begin
                        dir   <= req_dir;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (freeze) begin
                        state <= ST_FROZEN;
                    end else begin
                        dir <= eff_dir;
                        if (move_tick && blocked) begin
                            wall_q <= 1'b1;
                            state  <= ST_FROZEN;
                        end else if (do_move) begin
                            for (int i = MAX_LEN - 1; i > 0; i--) begin
                                seg_x[i] <= seg_x[i-1];
                                seg_y[i] <= seg_y[i-1];
                            end
                            seg_x[0] <= head_x_next;
                            seg_y[0] <= head_y_next;
                            moved    <= 1'b1;
                            if (grow_pending != 3'd0 && length < MAX_LEN_W)
                                length <= length + 6'd1;
                        end
                    end
                end
                default: state <= ST_FROZEN;
            endcase
        end
    end

    // Pack the per-segment registers onto the flat coordinate buses.
    always_comb begin
        snakepos_x = '0;
        snakepos_y = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            snakepos_x[11*i +: 11] = seg_x[i];
            snakepos_y[11*i +: 11] = seg_y[i];
        end
    end

endmodule
